adder_seq_ctrl: RTL and testbench
=================================

Name: adder_seq_ctrl

Overview:
- Multi-cycle 64-bit add/subtract controller for the ALU, used where area matters more than latency (e.g. the non-critical address/stack-pointer path).
- Owns one SLICE-bit ripple slice and sequences it over WIDTH/SLICE cycles, registering the inter-slice carry between cycles.
- Accepts operands on a valid/ready handshake and returns the result with flags on a second valid/ready handshake.
- Flag semantics match the single-cycle 64-bit adder:
  - cout is the raw carry out of the MSB.
  - of is the carry into the MSB XOR the carry out of the MSB.

Parameters:
WIDTH, 64, operand/result width; must be an integer multiple of SLICE.
SLICE, 16, bits processed per cycle; NSLICE = WIDTH/SLICE (default 4).

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
in_valid  in  1  operand request valid.
in_ready  out  1  controller can accept operands.
a  in  WIDTH  operand A.
b  in  WIDTH  operand B.
sub  in  1  1 = A - B (A + ~B + 1), 0 = A + B.
abort  in  1  synchronous cancel of an in-flight operation.
out_valid  out  1  result and flags valid.
out_ready  in  1  consumer accepts result.
result  out  WIDTH  sum/difference.
cout  out  1  carry out of MSB (for sub: 1 = no borrow).
of  out  1  signed overflow.
zf  out  1  result == 0.
sf  out  1  result[WIDTH-1].
busy  out  1  high in RUN.

Behaviour:
- Reset (rst_n low, asynchronous, any state):
  - State goes to IDLE.
  - in_ready=0 while rst_n low, then 1 on the first cycle after release.
  - out_valid, busy, result, cout, of, zf, sf all go to 0.
  - Slice index, carry register and operand registers clear.
- FSM states IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid && in_ready:
    - Latch a into opA.
    - Latch b ^ {WIDTH{sub}} into opB.
    - Set carry register = sub.
    - Set index k=0.
    - Go to RUN.
  - abort is ignored in IDLE.
- RUN:
  - in_ready=0, busy=1.
  - Each cycle: {c, s} = opA[k-slice] + opB[k-slice] + carry. Write s into result[k*SLICE +: SLICE], then carry <= c, k <= k+1.
  - On slice NSLICE-1, also capture the carry into bit WIDTH-1; of = that carry XOR c.
  - After the last slice: cout <= c, zf/sf computed from the full result, go to DONE.
  - a, b and sub changes during RUN have no effect.
- Latency: acceptance at edge 0 → out_valid high after edge NSLICE (4 cycles for defaults).
- DONE:
  - out_valid=1; result and flags held stable.
  - On out_ready: go to IDLE.
  - With out_ready low, stay in DONE indefinitely and hold all outputs.
  - in_ready=0 in DONE, so there is no same-cycle accept on the handshake edge. Minimum issue interval is NSLICE+2 cycles.
- abort:
  - High in RUN: go to IDLE next edge; out_valid never asserts for that operation; flags are not updated.
  - High in DONE: ignored; the result is still delivered.
- Between operations, result and flags keep the last delivered values. The partially written result is not visible, because out_valid=0.
- zf/sf/of/cout are registered and change only on the RUN→DONE transition.

Test Plan:
- Add 5 + 7, sub=0, out_ready=1 → out_valid exactly 4 cycles after accept; result=12, cout=0, of=0, zf=0, sf=0.
- 0x7FFFFFFFFFFFFFFF + 1 → result=0x8000000000000000, of=1, sf=1, cout=0, zf=0 (carry ripples through all 4 slice boundaries).
- Sub 5 - 5 → result=0, zf=1, cout=1, of=0.
- Sub 0x8000000000000000 - 1 → result=0x7FFFFFFFFFFFFFFF, of=1, cout=1, sf=0.
- 0xFFFFFFFFFFFFFFFF + 1 with out_ready held low 3 cycles:
  - result=0, cout=1, zf=1, of=0.
  - out_valid and values stay stable; in_ready stays 0.
  - After the handshake, in_ready=1 next cycle; a second request with in_valid held high is accepted then.
- Interruptions:
  - abort in 2nd RUN cycle → IDLE next cycle, no out_valid, previous flags unchanged.
  - rst_n pulsed low mid-RUN → all outputs 0 immediately (without a clock edge), in_ready=1 after release.

Source files
------------

// File: rtl/adder_seq_ctrl.sv
// Multi-cycle add/subtract controller: one SLICE-bit ripple slice reused
// over WIDTH/SLICE cycles with a registered inter-slice carry.
module adder_seq_ctrl #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             of,
  output logic             zf,
  output logic             sf,
  output logic             busy
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int KW = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [KW-1:0] KLAST = KW'(NSLICE - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_e;

  state_e state_q, state_d;

  logic [NSLICE-1:0][SLICE-1:0] opa_q, opa_d;
  logic [NSLICE-1:0][SLICE-1:0] opb_q, opb_d;
  logic [NSLICE-1:0][SLICE-1:0] res_q, res_d;
  logic [KW-1:0] k_q, k_d;
  logic c_q, c_d;
  logic cout_q, cout_d;
  logic of_q, of_d;
  logic zf_q, zf_d;
  logic sf_q, sf_d;

  logic [SLICE:0] sum;
  logic cmsb;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      k_q     <= '0;
      c_q     <= 1'b0;
      cout_q  <= 1'b0;
      of_q    <= 1'b0;
      zf_q    <= 1'b0;
      sf_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      k_q     <= k_d;
      c_q     <= c_d;
      cout_q  <= cout_d;
      of_q    <= of_d;
      zf_q    <= zf_d;
      sf_q    <= sf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    k_d     = k_q;
    c_d     = c_q;
    cout_d  = cout_q;
    of_d    = of_q;
    zf_d    = zf_q;
    sf_d    = sf_q;

    sum = {1'b0, opa_q[k_q]} + {1'b0, opb_q[k_q]}
        + (SLICE+1)'(c_q);
    // carry into the slice MSB recovered from its sum bit
    cmsb = sum[SLICE-1] ^ opa_q[k_q][SLICE-1]
         ^ opb_q[k_q][SLICE-1];

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          opa_d   = a;
          opb_d   = b ^ {WIDTH{sub}};
          c_d     = sub;
          k_d     = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        if (abort) begin
          state_d = IDLE;
        end else begin
          res_d[k_q] = sum[SLICE-1:0];
          c_d = sum[SLICE];
          k_d = k_q + 1'b1;
          if (k_q == KLAST) begin
            cout_d  = sum[SLICE];
            of_d    = cmsb ^ sum[SLICE];
            zf_d    = ~|res_d;
            sf_d    = res_d[NSLICE-1][SLICE-1];
            state_d = DONE;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready  = rst_n & (state_q == IDLE);
  assign busy      = (state_q == RUN);
  assign out_valid = (state_q == DONE);
  assign result    = res_q;
  assign cout      = cout_q;
  assign of        = of_q;
  assign zf        = zf_q;
  assign sf        = sf_q;

endmodule

// File: tb/tb_adder_seq_ctrl.sv
// Scoreboard bench for adder_seq_ctrl: directed vectors, queued
// expectations, separate output monitor.
module tb_adder_seq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] a = '0;
  logic [63:0] b = '0;
  logic        sub = 1'b0;
  logic        abort = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] result;
  logic        cout, of, zf, sf, busy;

  typedef struct {
    logic [63:0] r;
    logic c, o, z, s;
    int acc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic ov_prev = 1'b0;

  adder_seq_ctrl #(.WIDTH(64), .SLICE(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .abort(abort),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .cout(cout), .of(of),
    .zf(zf), .sf(sf), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // monitor: latency at out_valid rise, values at handshake
  always @(negedge clk) begin
    if (out_valid && !ov_prev) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_out_valid: got 1 expected 0");
      end else begin
        chk("latency", 64'(cyc - sb[0].acc), 64'd4);
      end
    end
    if (out_valid && out_ready && sb.size() != 0) begin
      me = sb.pop_front();
      chk("result", result, me.r);
      chk("cout", {63'd0, cout}, {63'd0, me.c});
      chk("of", {63'd0, of}, {63'd0, me.o});
      chk("zf", {63'd0, zf}, {63'd0, me.z});
      chk("sf", {63'd0, sf}, {63'd0, me.s});
    end
    ov_prev = out_valid;
  end

  task automatic issue(input logic [63:0] ia, ib,
                       input logic isub,
                       input logic [63:0] er,
                       input logic ec, eo, ez, es,
                       input bit push);
    int n;
    int accp;
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = ia;
    b = ib;
    sub = isub;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("accept_timeout", 64'd0, 64'd1);
    accp = cyc + 1;
    @(posedge clk);
    if (push) begin
      e.r = er; e.c = ec; e.o = eo;
      e.z = ez; e.s = es; e.acc = accp;
      sb.push_back(e);
    end
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      chk("drain_timeout", 64'(sb.size()), 64'd0);
      sb.delete();
    end
  endtask

  initial begin
    int n;
    int accp;
    exp_t e;
    #2;
    chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_result", result, 64'd0);
    chk("rst_flags", {60'd0, cout, of, zf, sf}, 64'd0);
    #10;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);

    issue(64'd5, 64'd7, 1'b0, 64'd12, 0, 0, 0, 0, 1);
    drain();
    issue(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          64'h8000_0000_0000_0000, 0, 1, 0, 1, 1);
    drain();
    issue(64'd5, 64'd5, 1'b1, 64'd0, 1, 0, 1, 0, 1);
    drain();
    issue(64'h8000_0000_0000_0000, 64'd1, 1'b1,
          64'h7FFF_FFFF_FFFF_FFFF, 1, 1, 0, 0, 1);
    drain();

    // back-pressure with a second request waiting
    out_ready = 1'b0;
    issue(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0,
          64'd0, 1, 0, 1, 0, 1);
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("hold_reach_done", {63'd0, out_valid}, 64'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a = 64'hFFFF_FFFF_FFFF_FFFF;
    b = 64'd0;
    sub = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("hold_out_valid", {63'd0, out_valid}, 64'd1);
      chk("hold_in_ready", {63'd0, in_ready}, 64'd0);
      chk("hold_result", result, 64'd0);
      chk("hold_cout", {63'd0, cout}, 64'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("b2b_in_ready", {63'd0, in_ready}, 64'd1);
    chk("b2b_out_valid", {63'd0, out_valid}, 64'd0);
    accp = cyc + 1;
    @(posedge clk);
    e.r = 64'hFFFF_FFFF_FFFF_FFFF;
    e.c = 0; e.o = 0; e.z = 0; e.s = 1;
    e.acc = accp;
    sb.push_back(e);
    #1;
    in_valid = 1'b0;
    drain();

    // abort in the second RUN cycle
    issue(64'd5, 64'd5, 1'b1, 64'd0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", {63'd0, busy}, 64'd0);
    chk("abort_in_ready", {63'd0, in_ready}, 64'd1);
    chk("abort_flags", {60'd0, cout, of, zf, sf}, 64'h1);
    repeat (8) @(negedge clk);

    // async reset mid-RUN
    issue(64'd1, 64'd2, 1'b0, 64'd0, 0, 0, 0, 0, 0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", {63'd0, busy}, 64'd0);
    chk("mrst_in_ready", {63'd0, in_ready}, 64'd0);
    chk("mrst_result", result, 64'd0);
    chk("mrst_flags", {60'd0, cout, of, zf, sf}, 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("mrst_release_ready", {63'd0, in_ready}, 64'd1);
    chk("mrst_out_valid", {63'd0, out_valid}, 64'd0);

    issue(64'd3, 64'd5, 1'b1,
          64'hFFFF_FFFF_FFFF_FFFE, 0, 0, 0, 1, 1);
    drain();
    issue(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001,
          1'b0, 64'h0001_0000_0001_0000, 0, 0, 0, 0, 1);
    drain();

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
